// File: rtl/decode_wb_if.sv
// Fetch/execute-facing bundle of the SEQ decode/write-back stage.
// The master drives the fetch/execute results and reads back IDs, operands and status.
interface decode_wb_if #(
  parameter int CNT_W = 32
);
  logic              instr_valid;
  logic [3:0]        in_code;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic              cnd;
  logic              flag_halt;
  logic              in_error;
  logic              bad_mem;
  logic [63:0]       val_e;
  logic [63:0]       val_m;
  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic [63:0]       val_a;
  logic [63:0]       val_b;
  logic              stopped;
  logic [CNT_W-1:0]  retire_count;
  logic [3:0]        dbg_sel;
  logic [63:0]       dbg_val;

  modport master (
    output instr_valid, in_code, ra, rb, cnd, flag_halt, in_error, bad_mem,
           val_e, val_m, dbg_sel,
    input  src_a, src_b, dst_e, dst_m, val_a, val_b, stopped, retire_count, dbg_val
  );

  modport slave (
    input  instr_valid, in_code, ra, rb, cnd, flag_halt, in_error, bad_mem,
           val_e, val_m, dbg_sel,
    output src_a, src_b, dst_e, dst_m, val_a, val_b, stopped, retire_count, dbg_val
  );
endinterface

// File: rtl/decode_wb_seq.sv
// SEQ Y86-64 decode/write-back: register ID selection, 15-entry register file with
// combinational reads, edge-committed writes, RUN/STOPPED control and retire counter.
module decode_wb_seq #(
  parameter int NREG   = 15,
  parameter int RSP_ID = 4,
  parameter int CNT_W  = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  decode_wb_if.slave   bus
);

  localparam logic [3:0] NONE = 4'hF;
  localparam logic [3:0] RSP  = 4'(RSP_ID);

  localparam logic [3:0] OP_HALT   = 4'd0;
  localparam logic [3:0] OP_NOP    = 4'd1;
  localparam logic [3:0] OP_RRMOV  = 4'd2;
  localparam logic [3:0] OP_IRMOV  = 4'd3;
  localparam logic [3:0] OP_RMMOV  = 4'd4;
  localparam logic [3:0] OP_MRMOV  = 4'd5;
  localparam logic [3:0] OP_OPQ    = 4'd6;
  localparam logic [3:0] OP_JXX    = 4'd7;
  localparam logic [3:0] OP_CALL   = 4'd8;
  localparam logic [3:0] OP_RET    = 4'd9;
  localparam logic [3:0] OP_PUSH   = 4'd10;
  localparam logic [3:0] OP_POP    = 4'd11;

  typedef enum logic {RUN, STOPPED} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [63:0]       regs [NREG];
  logic [CNT_W-1:0]  retire_q;
  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic              fault;
  logic              commit;

  // ID selection from the fetched instruction; unknown codes select nothing.
  always_comb begin
    src_a = NONE;
    src_b = NONE;
    dst_e = NONE;
    dst_m = NONE;
    case (bus.in_code)
      OP_RRMOV: begin
        src_a = bus.ra;
        dst_e = bus.cnd ? bus.rb : NONE;
      end
      OP_IRMOV: dst_e = bus.rb;
      OP_RMMOV: begin
        src_a = bus.ra;
        src_b = bus.rb;
      end
      OP_MRMOV: begin
        src_b = bus.rb;
        dst_m = bus.ra;
      end
      OP_OPQ: begin
        src_a = bus.ra;
        src_b = bus.rb;
        dst_e = bus.rb;
      end
      OP_CALL: begin
        src_b = RSP;
        dst_e = RSP;
      end
      OP_RET: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
      end
      OP_PUSH: begin
        src_a = bus.ra;
        src_b = RSP;
        dst_e = RSP;
      end
      OP_POP: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        dst_m = bus.ra;
      end
      OP_HALT, OP_NOP, OP_JXX: ;
      default: ;
    endcase
  end

  assign fault  = bus.flag_halt | bus.in_error | bus.bad_mem;
  assign commit = bus.instr_valid & (state_q == RUN) & ~fault;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.instr_valid && fault) state_d = STOPPED;
      STOPPED: state_d = STOPPED;
      default: state_d = RUN;
    endcase
  end

  // The M write is issued last so it takes precedence when both ports hit one register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      if (dst_e != NONE) regs[dst_e] <= bus.val_e;
      if (dst_m != NONE) regs[dst_m] <= bus.val_m;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retire_q <= '0;
    end else if (commit) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign bus.src_a        = src_a;
  assign bus.src_b        = src_b;
  assign bus.dst_e        = dst_e;
  assign bus.dst_m        = dst_m;
  assign bus.val_a        = (src_a == NONE) ? 64'd0 : regs[src_a];
  assign bus.val_b        = (src_b == NONE) ? 64'd0 : regs[src_b];
  assign bus.dbg_val      = (bus.dbg_sel == NONE) ? 64'd0 : regs[bus.dbg_sel];
  assign bus.stopped      = (state_q == STOPPED);
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_decode_wb_seq.sv
// Bench for decode_wb_seq: directed scenarios with literal expectations, then random
// instruction streams checked every cycle against an architectural model.
module tb_decode_wb_seq;

  logic clock = 1'b0;
  logic reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  decode_wb_if #(.CNT_W(32)) bus ();

  decode_wb_seq #(.NREG(15), .RSP_ID(4), .CNT_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Architectural model: register array with a hard-wired zero at index 15.
  logic [63:0] m_regs [16] = '{default: 64'd0};
  logic        m_stopped = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ids(input logic [3:0] code, input logic [3:0] a, input logic [3:0] b,
                              input logic c, output logic [3:0] sa, output logic [3:0] sb,
                              output logic [3:0] de, output logic [3:0] dm);
    int ic;
    ic = int'(code);
    sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
    if (ic inside {2, 4, 6, 10}) sa = a;
    if (ic inside {9, 11})       sa = 4'd4;
    if (ic inside {4, 5, 6})     sb = b;
    if (ic inside {8, 9, 10, 11}) sb = 4'd4;
    if (ic inside {3, 6})        de = b;
    if (ic == 2)                 de = c ? b : 4'hF;
    if (ic inside {8, 9, 10, 11}) de = 4'd4;
    if (ic inside {5, 11})       dm = a;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    logic [3:0] sa, sb, de, dm;
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
      m_stopped = 1'b0;
      m_cnt     = 32'd0;
    end else if (bus.instr_valid && !m_stopped) begin
      if (bus.flag_halt || bus.in_error || bus.bad_mem) begin
        m_stopped = 1'b1;
      end else begin
        ids(bus.in_code, bus.ra, bus.rb, bus.cnd, sa, sb, de, dm);
        if (de != 4'hF) m_regs[de] = bus.val_e;
        if (dm != 4'hF) m_regs[dm] = bus.val_m;
        m_cnt = m_cnt + 32'd1;
      end
    end
  end

  always @(negedge clock) begin
    logic [3:0] sa, sb, de, dm;
    ids(bus.in_code, bus.ra, bus.rb, bus.cnd, sa, sb, de, dm);
    chk("src_a", 64'(bus.src_a), 64'(sa));
    chk("src_b", 64'(bus.src_b), 64'(sb));
    chk("dst_e", 64'(bus.dst_e), 64'(de));
    chk("dst_m", 64'(bus.dst_m), 64'(dm));
    chk("val_a", bus.val_a, m_regs[sa]);
    chk("val_b", bus.val_b, m_regs[sb]);
    chk("dbg_val", bus.dbg_val, m_regs[bus.dbg_sel]);
    chk("stopped", 64'(bus.stopped), 64'(m_stopped));
    chk("retire_count", 64'(bus.retire_count), 64'(m_cnt));
  end

  task automatic apply(input logic v, input logic [3:0] code, input logic [3:0] a,
                       input logic [3:0] b, input logic c, input logic h, input logic e,
                       input logic bm, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] ds);
    bus.instr_valid = v;
    bus.in_code     = code;
    bus.ra          = a;
    bus.rb          = b;
    bus.cnd         = c;
    bus.flag_halt   = h;
    bus.in_error    = e;
    bus.bad_mem     = bm;
    bus.val_e       = ve;
    bus.val_m       = vm;
    bus.dbg_sel     = ds;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    apply(0, 4'd1, 4'hF, 4'hF, 0, 0, 0, 0, 64'd0, 64'd0, 4'hF);
    #12;
    reset_n = 1'b1;
    tick();
    chk("reset_stopped", 64'(bus.stopped), 64'd0);
    chk("reset_count", 64'(bus.retire_count), 64'd0);

    // irmov $0x10, %rdx
    apply(1, 4'd3, 4'hF, 4'd2, 0, 0, 0, 0, 64'h10, 64'd0, 4'd2);
    #1;
    chk("irmov_dst_e", 64'(bus.dst_e), 64'd2);
    tick();
    apply(0, 4'd1, 4'hF, 4'hF, 0, 0, 0, 0, 64'd0, 64'd0, 4'd2);
    #1;
    chk("irmov_r2", bus.dbg_val, 64'h10);
    chk("irmov_count", 64'(bus.retire_count), 64'd1);

    // cmov not taken, then taken
    apply(1, 4'd2, 4'd2, 4'd3, 0, 0, 0, 0, 64'h10, 64'd0, 4'd3);
    #1;
    chk("cmov0_dst_e", 64'(bus.dst_e), 64'hF);
    tick();
    apply(1, 4'd2, 4'd2, 4'd3, 1, 0, 0, 0, 64'h10, 64'd0, 4'd3);
    #1;
    chk("cmov0_r3", bus.dbg_val, 64'd0);
    chk("cmov0_count", 64'(bus.retire_count), 64'd2);
    tick();
    apply(0, 4'd1, 4'hF, 4'hF, 0, 0, 0, 0, 64'd0, 64'd0, 4'd3);
    #1;
    chk("cmov1_r3", bus.dbg_val, 64'h10);

    // popq %rsp: M write beats E write
    apply(1, 4'd11, 4'd4, 4'hF, 0, 0, 0, 0, 64'h108, 64'hAA, 4'd4);
    #1;
    chk("pop_src_a", 64'(bus.src_a), 64'd4);
    chk("pop_src_b", 64'(bus.src_b), 64'd4);
    chk("pop_dst_e", 64'(bus.dst_e), 64'd4);
    chk("pop_dst_m", 64'(bus.dst_m), 64'd4);
    tick();
    apply(0, 4'd1, 4'hF, 4'hF, 0, 0, 0, 0, 64'd0, 64'd0, 4'd4);
    #1;
    chk("pop_r4", bus.dbg_val, 64'hAA);
    chk("pop_count", 64'(bus.retire_count), 64'd4);

    // OPq reading and writing r2 in the same cycle
    apply(1, 4'd6, 4'd2, 4'd2, 0, 0, 0, 0, 64'h20, 64'd0, 4'd2);
    #1;
    chk("opq_val_a_old", bus.val_a, 64'h10);
    chk("opq_val_b_old", bus.val_b, 64'h10);
    tick();
    bus.instr_valid = 1'b0;
    #1;
    chk("opq_val_a_new", bus.val_a, 64'h20);
    chk("opq_val_b_new", bus.val_b, 64'h20);

    // halt, then a blocked irmov
    apply(1, 4'd0, 4'hF, 4'hF, 0, 1, 0, 0, 64'd0, 64'd0, 4'd5);
    tick();
    apply(1, 4'd3, 4'hF, 4'd5, 0, 0, 0, 0, 64'd7, 64'd0, 4'd5);
    #1;
    chk("halt_stopped", 64'(bus.stopped), 64'd1);
    chk("halt_count", 64'(bus.retire_count), 64'd5);
    tick();
    apply(0, 4'd1, 4'hF, 4'hF, 0, 0, 0, 0, 64'd0, 64'd0, 4'd5);
    #1;
    chk("stopped_r5", bus.dbg_val, 64'd0);
    chk("stopped_count", 64'(bus.retire_count), 64'd5);

    // asynchronous reset mid-cycle while stopped
    bus.dbg_sel = 4'd2;
    #1;
    chk("pre_reset_r2", bus.dbg_val, 64'h20);
    reset_n = 1'b0;
    #1;
    chk("async_stopped", 64'(bus.stopped), 64'd0);
    chk("async_r2", bus.dbg_val, 64'd0);
    chk("async_count", 64'(bus.retire_count), 64'd0);
    #2;
    reset_n = 1'b1;

    // random instruction stream with occasional faults and mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      int r;
      tick();
      r = int'($urandom_range(0, 99));
      apply(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), (r == 0), (r == 1), (r == 2),
            {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 59) == 0) begin
        #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
